// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl
// Iterative sequencer for the ALU multiply / divide / negate path.
// One operation is accepted per start/busy/done handshake. Operands are
// reduced to magnitudes when signed, an N-step shift-add multiply or
// restoring divide runs one step per cycle, and the result is then
// re-signed and packed.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   start      request pulse, honoured only in IDLE
//   op[3:0]    [3:2] 00 mul, 01 div, 10 negate, 11 reserved
//              [1] signed, [0] 1 = full width, 0 = half width
//   a, b       operand A / dividend, operand B / divisor
//   busy       high in PREP, RUN, FIXUP
//   done       one-cycle pulse in DONE
//   err        divide-by-zero or reserved op; held until next accept
//   result_lo  product low / quotient / negation
//   result_hi  product high / remainder
module muldiv_seq_ctrl #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result_lo,
  output logic [W-1:0] result_hi
);

  localparam int unsigned H = W / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_DIV,
    OP_NEG,
    OP_RSV
  } op_kind_t;

  state_t   state, state_next;
  op_kind_t kind;

  // Latched request
  logic [3:0]   op_q;
  logic [W-1:0] a_q, b_q;

  // Working registers
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mplier;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   dvsr;
  logic           neg_q;     // product / quotient sign
  logic           rsign_q;   // remainder sign (dividend sign)
  logic [CW-1:0]  cnt;

  // Operand conditioning
  logic           wide, sgn;
  logic [W-1:0]   a_m, b_m;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_neg_v, b_neg_v;
  logic [W-1:0]   a_mag, b_mag;

  // Divide step
  logic [W:0]     r_shift;
  logic           ge;
  logic [W-1:0]   r_diff;
  logic [W-1:0]   rem_next;

  // Fixup results
  logic [2*W-1:0] p_fix;
  logic [W-1:0]   q_neg, r_neg, q_fix, r_fix;
  logic [W-1:0]   neg_a;
  logic [W-1:0]   fix_lo, fix_hi;

  assign kind = op_kind_t'(op_q[3:2]);
  assign wide = op_q[0];
  assign sgn  = op_q[1];

  always_comb begin
    a_m     = wide ? a_q : {{(W-H){1'b0}}, a_q[H-1:0]};
    b_m     = wide ? b_q : {{(W-H){1'b0}}, b_q[H-1:0]};
    a_neg   = sgn & (wide ? a_q[W-1] : a_q[H-1]);
    b_neg   = sgn & (wide ? b_q[W-1] : b_q[H-1]);
    a_neg_v = -a_m;
    b_neg_v = -b_m;
    if (!wide) begin
      a_neg_v[W-1:H] = '0;
      b_neg_v[W-1:H] = '0;
    end
    a_mag   = a_neg ? a_neg_v : a_m;
    b_mag   = b_neg ? b_neg_v : b_m;
  end

  // Restoring divide: the remainder gains one dividend bit, then the
  // divisor is subtracted if it fits. The shifted value needs W+1 bits,
  // but a successful difference is always below the divisor.
  always_comb begin
    r_shift  = {rem, quo[W-1]};
    ge       = (r_shift >= {1'b0, dvsr});
    r_diff   = r_shift[W-1:0] - dvsr;
    rem_next = ge ? r_diff : r_shift[W-1:0];
  end

  always_comb begin
    p_fix = neg_q ? -prod : prod;
    q_neg = -quo;
    r_neg = -rem;
    q_fix = neg_q ? q_neg : quo;
    r_fix = rsign_q ? r_neg : rem;
    neg_a = -a_m;
    if (!wide) begin
      q_fix[W-1:H] = sgn ? {(W-H){q_fix[H-1]}} : '0;
      r_fix[W-1:H] = sgn ? {(W-H){r_fix[H-1]}} : '0;
      neg_a[W-1:H] = '0;
    end

    fix_lo = '0;
    fix_hi = '0;
    case (kind)
      OP_MUL: begin
        fix_lo = p_fix[W-1:0];
        if (wide) begin
          fix_hi = p_fix[2*W-1:W];
        end else begin
          fix_hi = sgn ? {W{p_fix[W-1]}} : '0;
        end
      end
      OP_DIV: begin
        fix_lo = q_fix;
        fix_hi = r_fix;
      end
      OP_NEG: begin
        fix_lo = neg_a;
        fix_hi = '0;
      end
      default: begin
        fix_lo = '0;
        fix_hi = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_PREP;
      end
      S_PREP: begin
        case (kind)
          OP_MUL:  state_next = S_RUN;
          OP_DIV:  state_next = (b_m == '0) ? S_DONE : S_RUN;
          OP_NEG:  state_next = S_FIXUP;
          default: state_next = S_DONE;
        endcase
      end
      S_RUN: begin
        if (cnt == '0) state_next = S_FIXUP;
      end
      S_FIXUP: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand     <= '0;
      prod      <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      neg_q     <= 1'b0;
      rsign_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      busy <= (state_next == S_PREP) || (state_next == S_RUN) ||
              (state_next == S_FIXUP);
      done <= (state_next == S_DONE);

      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            err  <= 1'b0;
          end
        end
        S_PREP: begin
          neg_q   <= a_neg ^ b_neg;
          rsign_q <= a_neg;
          cnt     <= wide ? CW'(W - 1) : CW'(H - 1);
          prod    <= '0;
          mcand   <= {{W{1'b0}}, a_mag};
          mplier  <= b_mag;
          // Half-width dividends start at the top so the MSB shifts out first.
          quo     <= wide ? a_mag : (a_mag << H);
          rem     <= '0;
          dvsr    <= b_mag;
          if (kind == OP_DIV && b_m == '0) begin
            err       <= 1'b1;
            result_lo <= '1;
            result_hi <= a_m;
          end else if (kind == OP_RSV) begin
            err       <= 1'b1;
            result_lo <= '0;
            result_hi <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (kind == OP_DIV) begin
            rem <= rem_next;
            quo <= {quo[W-2:0], ge};
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        S_FIXUP: begin
          result_lo <= fix_lo;
          result_hi <= fix_hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed cases followed by
// randomized operations, all checked against an arithmetic reference model.
module tb_muldiv_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        busy, done, err;
  logic [15:0] result_lo, result_hi;

  int n_vec  = 0;
  int n_fail = 0;

  muldiv_seq_ctrl #(.W(16), .CW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sval(input longint v, input int n, input bit s);
    if (s && v[n-1]) return v - (longint'(1) << n);
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the operation definition.
  task automatic model(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] lo, output logic [15:0] hi,
                       output logic er, output int lat);
    int     n;
    bit     s;
    longint msk, am, bm, sa, sb, p, q, r;
    n   = o[0] ? 16 : 8;
    s   = o[1];
    msk = (longint'(1) << n) - 1;
    am  = longint'(av) & msk;
    bm  = longint'(bv) & msk;
    sa  = sval(am, n, s);
    sb  = sval(bm, n, s);
    lo  = '0;
    hi  = '0;
    er  = 1'b0;
    lat = n + 3;
    case (o[3:2])
      2'b00: begin
        p  = sa * sb;
        lo = p[15:0];
        if (n == 16) hi = p[31:16];
        else         hi = (s && p < 0) ? 16'hFFFF : 16'h0000;
      end
      2'b01: begin
        if (bm == 0) begin
          er  = 1'b1;
          lo  = 16'hFFFF;
          hi  = am[15:0];
          lat = 2;
        end else begin
          q = sa / sb;
          r = sa % sb;
          if (n == 16) begin
            lo = q[15:0];
            hi = r[15:0];
          end else if (s) begin
            lo = {{8{q[7]}}, q[7:0]};
            hi = {{8{r[7]}}, r[7:0]};
          end else begin
            lo = {8'h00, q[7:0]};
            hi = {8'h00, r[7:0]};
          end
        end
      end
      2'b10: begin
        p   = (-am) & msk;
        lo  = p[15:0];
        lat = 3;
      end
      default: begin
        er  = 1'b1;
        lat = 2;
      end
    endcase
  endtask

  // Issue one operation starting with inputs driven #1 after an edge while
  // the DUT is idle. Edge 1 is the accept edge. pulse_at injects a stray
  // start after that edge; rst_at asserts reset after that edge and ends
  // the operation with the abort checks.
  task automatic run_op(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input int pulse_at, input int rst_at);
    logic [15:0] e_lo, e_hi;
    logic        e_err;
    int          e_lat;
    int          e;
    bit          got;
    bit          busy_ok;
    bit          saw_done;
    string       t;
    model(o, av, bv, e_lo, e_hi, e_err, e_lat);
    t = $sformatf("op%h_a%h_b%h", o, av, bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk); #1;
    start = 1'b0;
    e     = 1;
    check({t, "_busy_at_accept"}, 32'(busy), 32'd1);
    check({t, "_err_cleared"}, 32'(err), 32'd0);
    got     = 1'b0;
    busy_ok = 1'b1;
    while (!got && e < 60) begin
      if (e == pulse_at) begin
        start = 1'b1;
        op    = 4'h5;
        a     = 16'h0001;
        b     = 16'h0000;
      end
      if (e == rst_at) rst_n = 1'b0;
      @(posedge clk); #1;
      e++;
      start = 1'b0;
      if (rst_at != 0 && e == rst_at + 1) begin
        check({t, "_rst_busy"}, 32'(busy), 32'd0);
        check({t, "_rst_done"}, 32'(done), 32'd0);
        check({t, "_rst_err"}, 32'(err), 32'd0);
        check({t, "_rst_lo"}, 32'(result_lo), 32'd0);
        check({t, "_rst_hi"}, 32'(result_hi), 32'd0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
          @(posedge clk); #1;
          if (done || busy) saw_done = 1'b1;
        end
        check({t, "_abort_no_activity"}, 32'(saw_done), 32'd0);
        return;
      end
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check({t, "_done_seen"}, 32'(got), 32'd1);
    check({t, "_latency"}, 32'(e), 32'(e_lat));
    check({t, "_busy_until_done"}, 32'(busy_ok), 32'd1);
    check({t, "_busy_at_done"}, 32'(busy), 32'd0);
    check({t, "_lo"}, 32'(result_lo), 32'(e_lo));
    check({t, "_hi"}, 32'(result_hi), 32'(e_hi));
    check({t, "_err"}, 32'(err), 32'(e_err));
    @(posedge clk); #1;
    check({t, "_done_pulse"}, 32'(done), 32'd0);
    check({t, "_lo_held"}, 32'(result_lo), 32'(e_lo));
  endtask

  initial begin
    logic [3:0]  ro;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b1;
    op    = 4'h1;
    a     = 16'h1234;
    b     = 16'h0010;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_lo", 32'(result_lo), 32'd0);
    check("reset_hi", 32'(result_hi), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", 32'(busy), 32'd0);

    run_op(4'b0001, 16'h1234, 16'h0010, 0, 0);
    run_op(4'b0010, 16'h00FD, 16'h0007, 0, 0);
    run_op(4'b0111, 16'hFFF9, 16'h0002, 0, 0);
    run_op(4'b0111, 16'h8000, 16'hFFFF, 0, 0);
    run_op(4'b0110, 16'h0080, 16'h00FF, 0, 0);
    run_op(4'b0101, 16'h0064, 16'h0000, 0, 0);
    run_op(4'b1100, 16'h1234, 16'h5678, 0, 0);
    run_op(4'b1001, 16'h0005, 16'h0000, 0, 0);
    run_op(4'b1000, 16'h0005, 16'h0000, 0, 0);
    run_op(4'b0011, 16'h8000, 16'h8000, 0, 0);
    run_op(4'b0100, 16'hFFFF, 16'h0003, 0, 0);

    run_op(4'b0001, 16'hBEEF, 16'h1234, 5, 0);
    run_op(4'b0011, 16'hABCD, 16'h0707, 0, 8);
    run_op(4'b0011, 16'hFFFE, 16'h0003, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom);
      if (ro[3:2] == 2'b11 && ($urandom_range(0, 3) != 0)) ro[3:2] = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 7))
        0:       ra = 16'h8000;
        1:       ra = 16'h0080;
        2:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'hFFFF;
        2:       rb = 16'h00FF;
        default: rb = 16'($urandom);
      endcase
      run_op(ro, ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Iterative sequencer for the ALU's multiply / divide / negate path.
- Accepts one operation via a start/busy/done handshake.
- Applies two's-complement pre-conditioning to operands (sign/magnitude), runs an N-step shift-add multiply or restoring divide, then post-complements the result.
- Op encoding is the same 4-bit code the ALU complement decoder uses, so both are driven from one op bus.

Parameters:
- W, 16, maximum operand width in bits; the 8-bit mode uses the low W/2 bits.
- CW, 5, iteration counter width (must hold W).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- op  in  4  [3:2]: 00 mul, 01 div, 10 negate, 11 reserved; [1]: 1 signed; [0]: 1 = 16-bit, 0 = 8-bit
- a  in  W  operand A / dividend; captured when start is accepted
- b  in  W  operand B / divisor; captured when start is accepted
- busy  out  1  high in PREP, RUN, FIXUP
- done  out  1  one-cycle pulse in DONE state
- err  out  1  divide-by-zero or reserved op; valid with done, held until next accept
- result_lo  out  W  product low / quotient / negation
- result_hi  out  W  product high / remainder

Behaviour:
- Reset: on any edge with rst_n=0, state=IDLE, and busy, done, err, result_lo, result_hi, counter and internal registers all clear to 0. This applies mid-operation; the aborted operation produces no done. start while rst_n=0 is ignored.
- N = 16 if op[0]=1, else 8. 8-bit mode uses a[7:0] and b[7:0] only.
- States and transitions:
  - IDLE: on start=1, latch op, a, b → PREP. start is ignored in every other state.
  - PREP: if signed and operand is negative (bit N-1 set), replace it by its magnitude. Record product/quotient sign = sA^sB and remainder sign = sA.
    - mul → RUN
    - div with b (masked) = 0 → DONE with err
    - negate → FIXUP
    - reserved → DONE with err
  - RUN: one iteration per cycle, counter N-1 down to 0.
    - mul: shift-add, LSB first.
    - div: restoring; shift in the dividend MSB, trial-subtract the divisor, set quotient bit if non-negative.
    - At counter 0 → FIXUP.
  - FIXUP:
    - mul: negate the 2N-bit product if the sign bit is set.
    - div: negate the quotient if the quotient sign is set; negate the remainder if sA.
    - negate: result = -a mod 2^N.
    - → DONE.
  - DONE: done=1, busy=0, results valid → IDLE next edge.
- Latency, counted in edges after the edge that accepts start:
  - mul/div: done at edge N+3 (19 for 16-bit, 11 for 8-bit).
  - negate: done at edge 3.
  - div-by-zero and reserved: done at edge 2.
- Result packing:
  - 16-bit mul: {result_hi, result_lo} = 32-bit product.
  - 8-bit mul: result_lo = 16-bit product; result_hi = sign extension of the product if signed, else 0.
  - div: result_lo = quotient, result_hi = remainder. In 8-bit mode both are extended from bit 7, sign-extended if signed, else zero-extended.
  - negate: result_lo = -a masked to N bits, upper bits 0; result_hi = 0. op[1] is ignored.
- Division truncates toward zero; the remainder takes the dividend's sign. -2^(N-1) / -1 gives quotient 0x8000 (16-bit) or 0xFF80 (8-bit sign-extended), remainder 0, err=0.
- Divide by zero: err=1, quotient all ones (0xFFFF), remainder = dividend as latched (masked to N, upper bits 0).
- Reserved op: err=1, both results 0.
- err is cleared when the next start is accepted.
- Outputs are registered. result_* hold their value from DONE until the next accepted start.

Test Plan:
- Unsigned 16-bit mul, op=0001, a=0x1234, b=0x0010 → {hi,lo}=0x00012340, err=0, done at edge 19, busy high edges 1–18.
- Signed 8-bit mul, op=0010, a=0x00FD, b=0x0007 → lo=0xFFEB, hi=0xFFFF, done at edge 11.
- Signed 16-bit div, op=0111, a=0xFFF9, b=0x0002 → lo=0xFFFD, hi=0xFFFF; then a=0x8000, b=0xFFFF → lo=0x8000, hi=0x0000, err=0.
- Div by zero, op=0101, a=0x0064, b=0x0000 → done at edge 2, err=1, lo=0xFFFF, hi=0x0064. Reserved op=1100 → done at edge 2, err=1, results 0.
- Negate, op=1001, a=0x0005 → lo=0xFFFB at edge 3. op=1000, a=0x0005 → lo=0x00FB, hi=0.
- Control boundaries:
  - Pulse start again at edge 5 of a 16-bit mul → ignored; first result unchanged.
  - Drop rst_n at edge 8 of a run → next edge all outputs 0, state IDLE, no done.
  - A new start afterwards completes normally.
